// File: rtl/ram_fill_pkg.sv
// Shared types and constants for the ram_fill block: FSM states, fill modes, parameter defaults.
package ram_fill_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 10;

  localparam logic FILL_CONST = 1'b0;
  localparam logic FILL_ADDR  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/ram_fill_if.sv
// Access and fill-control bundle between a requester (master) and ram_fill (slave).
interface ram_fill_if
  import ram_fill_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              req_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              fill_start;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_val;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output sel, we, addr, din, fill_start, fill_mode, fill_val,
    input  req_ready, dout, dout_valid, fill_busy, fill_done
  );

  modport slave (
    input  sel, we, addr, din, fill_start, fill_mode, fill_val,
    output req_ready, dout, dout_valid, fill_busy, fill_done
  );

endinterface

// File: rtl/ram_sp_core.sv
// Single-port storage: synchronous write, registered read; only the read register is reset.
module ram_sp_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_fill.sv
// Single-port RAM with a one-word-per-cycle whole-array fill engine (constant or 2*index pattern).
module ram_fill
  import ram_fill_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_fill_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic              mode_q, mode_nx;
  logic [DATA_W-1:0] val_q, val_nx;
  logic              done_q, done_nx;
  logic              valid_q, valid_nx;

  logic              mem_we_c;
  logic              mem_re_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [ADDR_W:0]   dbl_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      mode_q  <= FILL_CONST;
      val_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      mode_q  <= mode_nx;
      val_q   <= val_nx;
      done_q  <= done_nx;
      valid_q <= valid_nx;
    end
  end

  // Next state, fill sequencing and memory port steering
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    mode_nx     = mode_q;
    val_nx      = val_q;
    done_nx     = 1'b0;
    valid_nx    = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = bus.addr;
    mem_wdata_c = bus.din;
    dbl_c       = {idx, 1'b0};

    case (state)
      ST_IDLE: begin
        if (bus.sel) begin
          if (bus.we) begin
            mem_we_c = 1'b1;
          end else begin
            mem_re_c = 1'b1;
            valid_nx = 1'b1;
          end
        end
        if (bus.fill_start) begin
          state_nx = ST_FILL;
          idx_nx   = '0;
          mode_nx  = bus.fill_mode;
          val_nx   = bus.fill_val;
        end
      end
      ST_FILL: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = idx;
        mem_wdata_c = (mode_q == FILL_ADDR) ? DATA_W'(dbl_c) : val_q;
        if (idx == LAST_IDX) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
    endcase

    // Array has no reset, so block every access while reset is asserted
    if (!rst_n) begin
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;
    end
  end

  ram_sp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .addr  (mem_addr_c),
    .wdata (mem_wdata_c),
    .rdata (bus.dout)
  );

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.fill_busy  = (state == ST_FILL);
  assign bus.fill_done  = done_q;
  assign bus.dout_valid = valid_q;

endmodule
